// File: rtl/mdu_sequencer.sv
// -----------------------------------------------------------------------------
// mdu_sequencer
//
// Iterative multiply/divide unit and HI/LO register pair for the EX stage.
// MULT/MULTU run a radix-2 shift-add on operand magnitudes. DIV/DIVU run a
// restoring divide on operand magnitudes. Each takes DATA_WIDTH iteration
// cycles plus one sign-fix/commit cycle. MTHI/MTLO write HI/LO in one edge.
// o_stall holds any MDU op back while a sequence is in flight.
//
// Ports
//   i_clk      clock, rising edge
//   i_reset    synchronous active-high reset
//   i_flush    pipeline flush: aborts the in-flight sequence, blocks new ops
//   i_op       000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//              101 MTHI, 110 MTLO, 111 MFHI/MFLO (no action, read o_hi/o_lo)
//   i_data_a   rs: multiplicand / dividend / MTxx data
//   i_data_b   rt: multiplier / divisor
//   o_hi       HI register (product upper half / remainder)
//   o_lo       LO register (product lower half / quotient)
//   o_busy     sequence in flight
//   o_stall    combinational stall request, o_busy & (i_op != NOP)
//   o_done     one-cycle pulse the cycle after HI/LO are committed
// -----------------------------------------------------------------------------
module mdu_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int CTR_BUS_WIDTH = 3
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic [CTR_BUS_WIDTH-1:0] i_op,
    input  logic [DATA_WIDTH-1:0]    i_data_a,
    input  logic [DATA_WIDTH-1:0]    i_data_b,
    output logic [DATA_WIDTH-1:0]    o_hi,
    output logic [DATA_WIDTH-1:0]    o_lo,
    output logic                     o_busy,
    output logic                     o_stall,
    output logic                     o_done
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [CTR_BUS_WIDTH-1:0] OP_NOP   = CTR_BUS_WIDTH'(0);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_MULT  = CTR_BUS_WIDTH'(1);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_MULTU = CTR_BUS_WIDTH'(2);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_DIV   = CTR_BUS_WIDTH'(3);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_DIVU  = CTR_BUS_WIDTH'(4);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_MTHI  = CTR_BUS_WIDTH'(5);
    localparam logic [CTR_BUS_WIDTH-1:0] OP_MTLO  = CTR_BUS_WIDTH'(6);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Control state
    state_e          state_q, state_d;
    logic [CW-1:0]   ctr_q,   ctr_d;
    logic [W-1:0]    hi_q,    hi_d;
    logic [W-1:0]    lo_q,    lo_d;
    logic            done_q,  done_d;

    // Datapath state. acc holds {partial product, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide; opnd holds the multiplicand
    // or divisor magnitude.
    logic [2*W-1:0]  acc_q,    acc_d;
    logic [W-1:0]    opnd_q,   opnd_d;
    logic [W-1:0]    raw_a_q,  raw_a_d;
    logic            is_div_q, is_div_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;

    // Combinational helpers
    logic            op_start, op_signed, op_div;
    logic [W-1:0]    mag_a, mag_b;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    logic [W:0]      div_shift, div_trial;
    logic [2*W-1:0]  div_next;
    logic            neg_result;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix, rem_fix;

    always_comb begin
        op_start  = (i_op == OP_MULT) || (i_op == OP_MULTU) ||
                    (i_op == OP_DIV)  || (i_op == OP_DIVU);
        op_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
        op_div    = (i_op == OP_DIV)  || (i_op == OP_DIVU);

        // The most negative value maps onto itself, which is also its correct
        // unsigned magnitude.
        mag_a = (op_signed && i_data_a[W-1]) ? -i_data_a : i_data_a;
        mag_b = (op_signed && i_data_b[W-1]) ? -i_data_b : i_data_b;

        // Shift-add: add multiplicand into the upper half when the current
        // multiplier LSB is set, then shift the whole accumulator right.
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
        mul_next = {mul_sum, acc_q[W-1:1]};

        // Restoring divide: bring the next dividend bit into the remainder and
        // try subtracting. With a nonzero divisor the shifted remainder is
        // below twice the divisor, so the top trial bit is a clean borrow.
        div_shift = acc_q[2*W-1:W-1];
        div_trial = div_shift - {1'b0, opnd_q};
        div_next  = div_trial[W] ? {div_shift[W-1:0], acc_q[W-2:0], 1'b0}
                                 : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};

        neg_result = sign_a_q ^ sign_b_q;
        prod_fix   = neg_result ? -acc_q : acc_q;
        quo_fix    = neg_result ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix    = sign_a_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    end

    // NOTE: every signal written here gets a default before the case so that
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        raw_a_d  = raw_a_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;

        unique case (state_q)
            S_IDLE: begin
                if (!i_flush) begin
                    if (op_start) begin
                        state_d  = S_RUN;
                        ctr_d    = CW'(W - 1);
                        is_div_d = op_div;
                        sign_a_d = op_signed & i_data_a[W-1];
                        sign_b_d = op_signed & i_data_b[W-1];
                        raw_a_d  = i_data_a;
                        acc_d    = {{W{1'b0}}, (op_div ? mag_a : mag_b)};
                        opnd_d   = op_div ? mag_b : mag_a;
                    end else if (i_op == OP_MTHI) begin
                        hi_d = i_data_a;
                    end else if (i_op == OP_MTLO) begin
                        lo_d = i_data_a;
                    end
                end
            end

            S_RUN: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    if (ctr_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        ctr_d = ctr_q - CW'(1);
                    end
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                if (!i_flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (opnd_q == '0) begin
                        lo_d = {W{1'b1}};
                        hi_d = raw_a_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            ctr_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the sequence datapath has no reset; it is fully loaded on every
    // accepted op and is never observed while the FSM is idle.
    always_ff @(posedge i_clk) begin
        acc_q    <= acc_d;
        opnd_q   <= opnd_d;
        raw_a_q  <= raw_a_d;
        is_div_q <= is_div_d;
        sign_a_q <= sign_a_d;
        sign_b_q <= sign_b_d;
    end

    assign o_hi    = hi_q;
    assign o_lo    = lo_q;
    assign o_busy  = (state_q != S_IDLE);
    assign o_stall = o_busy & (i_op != OP_NOP);
    assign o_done  = done_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mdu_sequencer
//
// Table of mult/div vectors run back-to-back through a result scoreboard,
// plus hand-written sequences for reset, MTxx latency, stall length, MTLO
// held during busy, flush and reset mid-sequence.
// -----------------------------------------------------------------------------
module tb_mdu_sequencer;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MF    = 3'd7;
    localparam int         LATENCY  = 33;
    localparam int         BOUND    = 100;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_flush;
    logic [2:0]  i_op;
    logic [31:0] i_data_a;
    logic [31:0] i_data_b;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_busy;
    logic        o_stall;
    logic        o_done;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t vecs[$];

    mdu_sequencer #(
        .DATA_WIDTH    (32),
        .CTR_BUS_WIDTH (3)
    ) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_flush  (i_flush),
        .i_op     (i_op),
        .i_data_a (i_data_a),
        .i_data_b (i_data_b),
        .o_hi     (o_hi),
        .o_lo     (o_lo),
        .o_busy   (o_busy),
        .o_stall  (o_stall),
        .o_done   (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic add_vec(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.exp_hi = hi; v.exp_lo = lo;
        vecs.push_back(v);
    endtask

    // Presents a mult/div for one edge and records its expected result.
    task automatic start(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.name = name; e.hi = hi; e.lo = lo;
        sb.push_back(e);
        i_op = op; i_data_a = a; i_data_b = b;
        tick();
        i_op = OP_NOP;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!o_done && cyc < BOUND) begin
            tick();
            cyc++;
        end
    endtask

    task automatic sb_compare();
        exp_t e;
        check("sb_depth", 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, "_hi"}, {32'b0, o_hi}, {32'b0, e.hi});
            check({e.name, "_lo"}, {32'b0, o_lo}, {32'b0, e.lo});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          cyc;
        int          cnt;
        logic        done_seen;
        logic [31:0] ra, rb;
        logic [63:0] rp;

        i_reset = 1'b1; i_flush = 1'b0; i_op = OP_MF; i_data_a = '0; i_data_b = '0;

        // Vector table: directed corners, then random cases with model-computed results.
        add_vec("mult_neg2x3",   OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
        add_vec("multu_max",     OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        add_vec("div_m7_2",      OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        add_vec("div_ovf",       OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        add_vec("divu_by0",      OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF);
        add_vec("div_m7_by0",    OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
        add_vec("divu_100_7",    OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
        add_vec("div_7_m2",      OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
        add_vec("div_m8_m3",     OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2);
        add_vec("mult_7_m5",     OP_MULT,  32'd7,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD);
        add_vec("mult_minsq",    OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        add_vec("multu_zero",    OP_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000);
        add_vec("divu_max_1",    OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) begin
            ra = $urandom(); rb = $urandom();
            rp = {32'b0, ra} * {32'b0, rb};
            add_vec("rnd_multu", OP_MULTU, ra, rb, rp[63:32], rp[31:0]);
            rp = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
            add_vec("rnd_mult", OP_MULT, ra, rb, rp[63:32], rp[31:0]);
            rb = (i == 0) ? 32'($urandom_range(1, 65535)) : ($urandom() >> i) | 32'd1;
            add_vec("rnd_divu", OP_DIVU, ra, rb, ra % rb, ra / rb);
        end

        // Reset state
        tick(); tick();
        check("rst_hi",    {32'b0, o_hi}, 64'd0);
        check("rst_lo",    {32'b0, o_lo}, 64'd0);
        check("rst_busy",  64'(o_busy),   64'd0);
        check("rst_done",  64'(o_done),   64'd0);
        i_reset = 1'b0;
        tick();
        check("rst_stall", 64'(o_stall),  64'd0);
        i_op = OP_NOP;

        // MTHI / MTLO: one edge, never busy
        i_op = OP_MTHI; i_data_a = 32'hAAAA0000;
        tick();
        check("mthi_hi",   {32'b0, o_hi}, 64'h0000_0000_AAAA_0000);
        check("mthi_busy", 64'(o_busy),   64'd0);
        i_op = OP_MTLO; i_data_a = 32'h5555AAAA;
        tick();
        check("mtlo_lo",   {32'b0, o_lo}, 64'h0000_0000_5555_AAAA);
        check("mtlo_hi",   {32'b0, o_hi}, 64'h0000_0000_AAAA_0000);
        i_op = OP_NOP;

        // Flush during RUN: sequence discarded, HI/LO kept, no done pulse
        i_op = OP_MULT; i_data_a = 32'd3; i_data_b = 32'd4;
        tick();
        i_op = OP_NOP;
        check("flush_busy_pre", 64'(o_busy), 64'd1);
        for (int i = 0; i < 9; i++) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("flush_busy", 64'(o_busy),   64'd0);
        check("flush_hi",   {32'b0, o_hi}, 64'h0000_0000_AAAA_0000);
        check("flush_lo",   {32'b0, o_lo}, 64'h0000_0000_5555_AAAA);
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            done_seen |= o_done;
            tick();
        end
        check("flush_no_done", 64'(done_seen), 64'd0);

        // Ops presented together with flush in IDLE are ignored
        i_flush = 1'b1; i_op = OP_MULT;
        tick();
        check("flush_op_busy", 64'(o_busy), 64'd0);
        i_op = OP_MTHI; i_data_a = 32'h00000001;
        tick();
        check("flush_mthi_hi", {32'b0, o_hi}, 64'h0000_0000_AAAA_0000);
        i_flush = 1'b0; i_op = OP_NOP;

        // Vector table, issued back-to-back in each done cycle
        foreach (vecs[i]) begin
            start(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);
            check({vecs[i].name, "_busy"}, 64'(o_busy), 64'd1);
            if (i > 0) check({vecs[i].name, "_done_pulse"}, 64'(o_done), 64'd0);
            wait_done(cyc);
            check({vecs[i].name, "_latency"}, 64'(cyc), 64'(LATENCY));
            check({vecs[i].name, "_busy_end"}, 64'(o_busy), 64'd0);
            sb_compare();
        end

        // Dependent MFHI held from the cycle after acceptance
        start("stall_mult", OP_MULT, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
        i_op = OP_MF;
        #1;
        cnt = 0;
        while (o_stall && cnt < BOUND) begin
            cnt++;
            tick();
        end
        check("stall_cycles", 64'(cnt),    64'(LATENCY));
        check("stall_done",   64'(o_done), 64'd1);
        sb_compare();
        i_op = OP_NOP;
        tick();

        // MTLO held during busy: written only after the sequence commits
        start("mtlo_hold_mult", OP_MULT, 32'd7, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD);
        i_op = OP_MTLO; i_data_a = 32'h12345678;
        #1;
        cnt = 0;
        while (o_stall && cnt < BOUND) begin
            cnt++;
            tick();
        end
        check("mtlo_hold_done", 64'(o_done), 64'd1);
        sb_compare();
        tick();
        i_op = OP_NOP;
        check("mtlo_hold_lo", {32'b0, o_lo}, 64'h0000_0000_1234_5678);
        check("mtlo_hold_hi", {32'b0, o_hi}, 64'h0000_0000_FFFF_FFFF);

        // Reset in the middle of RUN
        i_op = OP_DIV; i_data_a = 32'd1000; i_data_b = 32'd3;
        tick();
        i_op = OP_NOP;
        for (int i = 0; i < 5; i++) tick();
        i_reset = 1'b1;
        tick();
        check("midrst_hi",   {32'b0, o_hi}, 64'd0);
        check("midrst_lo",   {32'b0, o_lo}, 64'd0);
        check("midrst_busy", 64'(o_busy),   64'd0);
        check("midrst_done", 64'(o_done),   64'd0);
        i_reset = 1'b0;
        tick();
        check("midrst_idle", 64'(o_busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative multiply/divide unit with the HI/LO register pair for the EX stage of the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from the EX-stage decode and runs a radix-2, one-bit-per-cycle shift-add or restoring-divide sequence over DATA_WIDTH cycles. It services MTHI/MTLO writes and MFHI/MFLO reads. It raises a stall toward the hazard unit whenever an HI/LO-dependent instruction arrives while a sequence is in flight.

## Interface
- DATA_WIDTH, 32, operand and HI/LO width; also the iteration count.
- CTR_BUS_WIDTH, 3, width of the op code.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_flush  in  1  pipeline flush; aborts the in-flight sequence.
- i_op  in  CTR_BUS_WIDTH  op code: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 MFHI/MFLO read.
- i_data_a  in  DATA_WIDTH  rs operand (dividend / multiplicand / MTxx data).
- i_data_b  in  DATA_WIDTH  rt operand (divisor / multiplier).
- o_hi  out  DATA_WIDTH  HI register.
- o_lo  out  DATA_WIDTH  LO register.
- o_busy  out  1  sequence in flight.
- o_stall  out  1  combinational stall request to the hazard unit.
- o_done  out  1  one-cycle pulse the cycle after HI/LO are committed.

## Operation
- FSM states:
  - IDLE → RUN on an accepted MULT/MULTU/DIV/DIVU.
  - RUN → FIX when the iteration counter reaches 0.
  - FIX → IDLE unconditionally.
  - Any state → IDLE on i_flush or i_reset.
- Accept rule: op 001–100 is accepted in IDLE when i_flush=0. On acceptance the unit:
  - latches the operand magnitudes,
  - latches the sign flags (signed ops only),
  - loads the counter with DATA_WIDTH-1.
- MULT/MULTU: 2·DATA_WIDTH-bit accumulator, shift-add on magnitudes. In FIX, the product is two's-complement negated if the operand signs differ (signed only). HI = upper half, LO = lower half.
- DIV/DIVU: restoring division on magnitudes, giving LO = quotient and HI = remainder. Signed sign fix:
  - quotient is negated if the signs differ;
  - remainder takes the sign of the dividend.
- Divide by zero: runs the full sequence, then commits LO = all ones and HI = i_data_a as latched (unsigned bit pattern), for both DIV and DIVU.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This result falls out of the magnitude path and needs no special case.
- MTHI/MTLO in IDLE: write i_data_a to HI/LO at the next edge.
- MFHI/MFLO: the EX stage reads o_hi/o_lo directly; the unit takes no action in IDLE.
- o_stall = o_busy & (i_op != NOP). It covers every MDU op, including MTxx and reads. Held ops are re-presented by the pipeline until the stall drops.
- i_flush in RUN or FIX: the sequence is discarded, HI/LO are unchanged, and o_done is not pulsed. If an MDU op is presented in the same cycle as i_flush, it is ignored.
- i_reset: HI = 0, LO = 0, state IDLE, counter 0, o_busy = 0, o_done = 0. Reset takes priority over i_flush and i_op.

## Timing
- Reset values: o_hi 0, o_lo 0, o_busy 0, o_stall 0 (since o_busy is 0), o_done 0.
- Op accepted at edge E0:
  - o_busy = 1 from after E0 through E(DATA_WIDTH+1).
  - RUN covers DATA_WIDTH cycles; FIX is 1 cycle.
  - HI/LO are committed at edge E(DATA_WIDTH+1), and o_busy falls at that edge.
  - o_done is high for exactly the cycle after E(DATA_WIDTH+1).
- Total latency with DATA_WIDTH = 32: 33 cycles from acceptance to valid HI/LO. A dependent MFHI presented at acceptance+1 stalls for 33 cycles.
- Back-to-back: a new mult/div may be accepted in the same cycle o_done is high, since the unit is already in IDLE.
- MTHI/MTLO latency: 1 edge, with no busy.
- o_stall is combinational from o_busy and i_op, with no added register delay.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → after 33 cycles: HI = 0xFFFFFFFF, LO = 0xFFFFFFFA, one o_done pulse.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- DIVU 0x12345678 / 0 → LO = 0xFFFFFFFF, HI = 0x12345678 after the full 33 cycles.
- MULT accepted, then i_op = MFHI held from the next cycle → o_stall = 1 for exactly 33 cycles, then 0 with o_hi valid. MTLO during busy is stalled and written only after o_done.
- MTHI 0xAAAA0000, then MULT started; i_flush at cycle 10 → o_busy drops at the next edge, HI stays 0xAAAA0000, no o_done. i_reset mid-RUN → HI = LO = 0 next edge.
